// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write initiator: FSM encoding, bus constants
// and the per-quarter bus drive decode.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_START    = 3'd2,
        ST_ADDR     = 3'd3,
        ST_ADDR_ACK = 3'd4,
        ST_DATA     = 3'd5,
        ST_DATA_ACK = 3'd6,
        ST_STOP     = 3'd7
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Returns {scl, sda_low} for a given state, quarter and outgoing bit.
    // Bit slots run scl low for Q0/Q1 and high for Q2/Q3 (scl = q[1]).
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                             input logic bit_val);
        logic [1:0] res;
        case (st)
            ST_START:                 res = {1'b1, q[1]};          // SDA falls mid-START
            ST_ADDR, ST_DATA:         res = {q[1], ~bit_val};      // open-drain: 1 = released
            ST_ADDR_ACK, ST_DATA_ACK: res = {q[1], 1'b0};          // master releases for ACK
            ST_STOP:                  res = {q[1], (q != 2'd3)};   // SDA released in Q3
            default:                  res = {1'b1, 1'b0};          // idle/setup: bus free
        endcase
        return res;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: registered one-cycle tick every CLK_DIV cycles
// while enabled; the count restarts from zero whenever en is low.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count clk cycles and emit a tick on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C write initiator: START, {addr, W}, ACK check, data byte,
// ACK check, STOP. SCL is push-pull, SDA is open-drain (0 or z).
// An 8-quarter bus-free phase precedes every START so back-to-back
// transactions always see idle bus time between STOP and the next START.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    inout  wire        sda
);

    state_t     state;
    logic [1:0] q;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [6:0] addr_r;
    logic [7:0] data_r;
    logic       ack_r;
    logic       sda_pre;
    logic       sda_low;
    logic       tick;
    logic [1:0] drive_s;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

    assign sda = sda_low ? 1'b0 : 1'bz;

    // Decode the bus levels wanted for the current state and quarter.
    always_comb begin
        drive_s = bus_drive(state, q, shift[7]);
    end

    // Transaction FSM, shift register and registered bus/status outputs.
    // SDA trails SCL by one clk so data never moves on a falling SCL edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            q       <= 2'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            addr_r  <= 7'h00;
            data_r  <= 8'h00;
            ack_r   <= I2C_NACK;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            scl     <= 1'b1;
            sda_pre <= 1'b0;
            sda_low <= 1'b0;
        end else begin
            done    <= 1'b0;
            scl     <= drive_s[1];
            sda_pre <= drive_s[0];
            sda_low <= sda_pre;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        busy    <= 1'b1;
                        addr_r  <= addr;
                        data_r  <= data_in;
                        nack    <= 1'b0;
                        q       <= 2'd0;
                        bit_cnt <= 3'd1;
                        state   <= ST_SETUP;
                    end
                end
                default: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (state)
                            ST_SETUP: begin
                                if (q == 2'd3) begin
                                    if (bit_cnt == 3'd0) begin
                                        state <= ST_START;
                                    end else begin
                                        bit_cnt <= bit_cnt - 3'd1;
                                    end
                                end
                            end
                            ST_START: begin
                                if (q == 2'd3) begin
                                    shift   <= {addr_r, RW_WRITE};
                                    bit_cnt <= 3'd7;
                                    state   <= ST_ADDR;
                                end
                            end
                            ST_ADDR, ST_DATA: begin
                                if (q == 2'd3) begin
                                    if (bit_cnt == 3'd0) begin
                                        state <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                                    end else begin
                                        shift   <= {shift[6:0], 1'b0};
                                        bit_cnt <= bit_cnt - 3'd1;
                                    end
                                end
                            end
                            ST_ADDR_ACK: begin
                                if (q == 2'd2) begin
                                    ack_r <= sda;
                                end else if (q == 2'd3) begin
                                    if (ack_r == I2C_ACK) begin
                                        shift   <= data_r;
                                        bit_cnt <= 3'd7;
                                        state   <= ST_DATA;
                                    end else begin
                                        nack  <= 1'b1;
                                        state <= ST_STOP;
                                    end
                                end
                            end
                            ST_DATA_ACK: begin
                                if (q == 2'd2) begin
                                    ack_r <= sda;
                                end else if (q == 2'd3) begin
                                    if (ack_r != I2C_ACK) begin
                                        nack <= 1'b1;
                                    end
                                    state <= ST_STOP;
                                end
                            end
                            ST_STOP: begin
                                if (q == 2'd3) begin
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench for i2c_master_controller: lane 0 runs CLK_DIV=4, lane 1
// runs CLK_DIV=2. Each lane has a bus monitor plus an ACK-configurable
// responder; expected bus bytes go to a scoreboard queue when a transfer is
// issued and are compared against what the monitor decoded from the pins.
module tb_i2c_master_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_v [2];
    logic [6:0] addr_v  [2];
    logic [7:0] data_v  [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       nack_v  [2];
    logic       scl_v   [2];
    logic       ack_addr[2];
    logic       ack_data[2];

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int tests = 0;
    int fails = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    localparam logic [9:0] STOP_MARK = 10'h200;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        wire        sda;
        logic       slave_low = 1'b0;
        logic       prev_scl  = 1'b1;
        logic       prev_sda  = 1'b1;
        int         cnt  = 0;
        int         bidx = 0;
        logic [8:0] cur  = 9'h000;

        pullup (sda);
        assign sda = slave_low ? 1'b0 : 1'bz;

        i2c_master_controller #(.CLK_DIV((g == 0) ? 4 : 2)) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[g]),
            .addr    (addr_v[g]),
            .data_in (data_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .nack    (nack_v[g]),
            .scl     (scl_v[g]),
            .sda     (sda)
        );

        // Bus monitor and responder: decodes START/STOP and 9-bit frames.
        always @(sda or scl_v[g]) begin
            if (scl_v[g] === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
                cnt  = 0;
                bidx = 0;
            end else if (scl_v[g] === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 &&
                         sda === 1'b1 && rst === 1'b0) begin
                if (g == 0) obs_q.push_back(STOP_MARK);
            end else if (scl_v[g] === 1'b1 && prev_scl === 1'b0) begin
                cur = {cur[7:0], sda};
                cnt++;
                if (cnt == 9) begin
                    if (g == 0) obs_q.push_back({1'b0, cur});
                    cnt = 0;
                    bidx++;
                end
            end else if (scl_v[g] === 1'b0 && prev_scl === 1'b1) begin
                slave_low = (cnt == 8) ? ((bidx == 0) ? ack_addr[g] : ack_data[g]) : 1'b0;
            end
            prev_scl = scl_v[g];
            prev_sda = sda;
        end
    end

    // Count done pulses per lane, sampled away from the active edge.
    always @(negedge clk) begin
        if (done_v[0] === 1'b1) done_cnt0++;
        if (done_v[1] === 1'b1) done_cnt1++;
    end

    function automatic logic [9:0] frame(input logic [7:0] b, input logic ack);
        return {1'b0, b, ack};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; start is high for exactly one edge.
    task automatic issue(input int g, input logic [6:0] a, input logic [7:0] d);
        start_v[g] = 1'b1;
        addr_v[g]  = a;
        data_v[g]  = d;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
    endtask

    // Wait for done on lane g (bounded); reports cycles and first low/high SCL runs.
    task automatic wait_done(input int g, input int limit, output int n, output int lo, output int hi);
        logic prev;
        int run;
        int nruns;
        n = 0; lo = 0; hi = 0; run = 0; nruns = 0;
        prev = scl_v[g];
        while (n < limit) begin
            @(posedge clk); #1;
            n++;
            if (scl_v[g] !== prev) begin
                if (nruns == 1) lo = run;
                if (nruns == 2) hi = run;
                nruns++;
                run = 1;
                prev = scl_v[g];
            end else begin
                run++;
            end
            if (done_v[g] === 1'b1) break;
        end
    endtask

    task automatic sb_check(input string tag);
        logic [9:0] e;
        logic [9:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
            chk(tag, 32'(o), 32'(e));
        end
        chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    initial begin
        int n;
        int lo;
        int hi;
        int d0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; addr_v[i] = 7'h00; data_v[i] = 8'h00;
            ack_addr[i] = 1'b1; ack_data[i] = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl",  32'(scl_v[0]),    32'd1);
        chk("rst_sda",  32'(lane[0].sda), 32'd1);
        chk("rst_busy", 32'(busy_v[0]),   32'd0);
        chk("rst_done", 32'(done_v[0]),   32'd0);
        chk("rst_nack", 32'(nack_v[0]),   32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs_q.delete();

        // 1: ACKed write 0x50 / 0xA5
        exp_q.push_back(frame(8'hA0, 1'b0));
        exp_q.push_back(frame(8'hA5, 1'b0));
        exp_q.push_back(STOP_MARK);
        issue(0, 7'h50, 8'hA5);
        chk("t1_busy", 32'(busy_v[0]), 32'd1);
        wait_done(0, 1000, n, lo, hi);
        chk("t1_latency", 32'(n), 32'd353);
        chk("t1_nack", 32'(nack_v[0]), 32'd0);
        chk("t1_busy_at_done", 32'(busy_v[0]), 32'd1);
        sb_check("t1_bus");

        // Back-to-back: start in the done cycle is ignored, next cycle accepted
        ack_addr[0] = 1'b0;
        start_v[0] = 1'b1; addr_v[0] = 7'h12; data_v[0] = 8'hFF;
        @(posedge clk); #1;
        chk("b2b_ignored", 32'(busy_v[0]), 32'd0);
        chk("b2b_done_pulse", 32'(done_v[0]), 32'd0);
        exp_q.push_back(frame(8'h24, 1'b1));
        exp_q.push_back(STOP_MARK);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("b2b_accepted", 32'(busy_v[0]), 32'd1);

        // 2: address NACK
        wait_done(0, 1000, n, lo, hi);
        chk("t2_latency", 32'(n), 32'd209);
        chk("t2_nack", 32'(nack_v[0]), 32'd1);
        sb_check("t2_bus");
        @(posedge clk); #1;

        // 3: data NACK
        ack_addr[0] = 1'b1; ack_data[0] = 1'b0;
        exp_q.push_back(frame(8'hA0, 1'b0));
        exp_q.push_back(frame(8'h3C, 1'b1));
        exp_q.push_back(STOP_MARK);
        issue(0, 7'h50, 8'h3C);
        wait_done(0, 1000, n, lo, hi);
        chk("t3_latency", 32'(n), 32'd353);
        chk("t3_nack", 32'(nack_v[0]), 32'd1);
        sb_check("t3_bus");
        @(posedge clk); #1;

        // 4: start pulsed mid-transfer is ignored
        ack_data[0] = 1'b1;
        d0 = done_cnt0;
        exp_q.push_back(frame(8'h54, 1'b0));
        exp_q.push_back(frame(8'h5A, 1'b0));
        exp_q.push_back(STOP_MARK);
        issue(0, 7'h2A, 8'h5A);
        repeat (100) @(posedge clk);
        #1;
        issue(0, 7'h7F, 8'h00);
        wait_done(0, 1000, n, lo, hi);
        chk("t4_latency", 32'(n + 101), 32'd353);
        chk("t4_nack", 32'(nack_v[0]), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_one_done", 32'(done_cnt0 - d0), 32'd1);
        sb_check("t4_bus");

        // 5: reset during DATA aborts at once, then a clean transfer
        issue(0, 7'h50, 8'hA5);
        repeat (220) @(posedge clk);
        #1;
        d0 = done_cnt0;
        rst = 1'b1;
        #1;
        chk("t5_rst_scl",  32'(scl_v[0]),    32'd1);
        chk("t5_rst_sda",  32'(lane[0].sda), 32'd1);
        chk("t5_rst_busy", 32'(busy_v[0]),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt0 - d0), 32'd0);
        obs_q.delete();
        exp_q.push_back(frame(8'h66, 1'b0));
        exp_q.push_back(frame(8'hC3, 1'b0));
        exp_q.push_back(STOP_MARK);
        issue(0, 7'h33, 8'hC3);
        wait_done(0, 1000, n, lo, hi);
        chk("t5_latency", 32'(n), 32'd353);
        chk("t5_nack", 32'(nack_v[0]), 32'd0);
        sb_check("t5_bus");

        // 6: CLK_DIV=2 boundary on lane 1
        d0 = done_cnt1;
        issue(1, 7'h50, 8'hA5);
        wait_done(1, 1000, n, lo, hi);
        chk("t6_latency", 32'(n), 32'd177);
        chk("t6_scl_low", 32'(lo), 32'd4);
        chk("t6_scl_high", 32'(hi), 32'd4);
        chk("t6_nack", 32'(nack_v[1]), 32'd0);
        @(posedge clk); #1;
        chk("t6_done_width", 32'(done_v[1]), 32'd0);
        chk("t6_one_done", 32'(done_cnt1 - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
